// File: rtl/savestate_sequencer_pkg.sv
// Shared types for the savestate sequencer: FSM states, transfer direction and per-direction
// status flags.
package savestate_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StPauseWait,
    StXfer,
    StXferWait,
    StResume,
    StDone
  } state_e;

  // Matches the xfer_dir pin: 0 = save (core->buffer), 1 = load.
  typedef enum logic {
    DirSave = 1'b0,
    DirLoad = 1'b1
  } dir_e;

  typedef struct packed {
    logic ack;
    logic busy;
    logic ok;
    logic err;
  } ss_status_t;

  localparam ss_status_t StatusIdle   = '{ack: 1'b0, busy: 1'b0, ok: 1'b0, err: 1'b0};
  localparam ss_status_t StatusAccept = '{ack: 1'b1, busy: 1'b1, ok: 1'b0, err: 1'b0};

  // Final report of a run; ok and err are mutually exclusive by construction.
  function automatic ss_status_t finish_status(input ss_status_t cur, input logic fail);
    ss_status_t s;
    s      = cur;
    s.ack  = 1'b0;
    s.busy = 1'b0;
    s.ok   = ~fail;
    s.err  = fail;
    return s;
  endfunction

endpackage

// File: rtl/savestate_sequencer_ss_watchdog.sv
// Loadable down-counter with zero flag; saturates at zero. Guards each wait phase.
module ss_watchdog #(
  parameter int unsigned TO_W = 24
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [TO_W-1:0] load_val,
  output logic            zero
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/savestate_sequencer.sv
// Savestate sequencer: accepts save/load requests from the host-command handler, pauses the
// core, runs one transfer through the save/load engine and reports ack/busy/ok/err status.
module savestate_sequencer
  import savestate_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 24'd12_000_000,
  parameter int unsigned TO_W           = 24
) (
  input  logic clk,
  input  logic reset_n,

  input  logic savestate_start,
  output logic savestate_start_ack,
  output logic savestate_start_busy,
  output logic savestate_start_ok,
  output logic savestate_start_err,

  input  logic savestate_load,
  output logic savestate_load_ack,
  output logic savestate_load_busy,
  output logic savestate_load_ok,
  output logic savestate_load_err,

  output logic pause_req,
  input  logic pause_ack,

  output logic xfer_start,
  output logic xfer_dir,
  input  logic xfer_done,
  input  logic xfer_error
);

  localparam logic [TO_W-1:0] WdLoad = TO_W'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  logic       fail_q, fail_d;
  logic       start_prev_q, load_prev_q;
  ss_status_t save_st_q, save_st_d;
  ss_status_t load_st_q, load_st_d;
  logic       pause_req_q, pause_req_d;
  logic       xfer_start_q, xfer_start_d;

  logic wd_load;
  logic wd_zero;
  logic start_rise;
  logic load_rise;

  assign start_rise = savestate_start & ~start_prev_q;
  assign load_rise  = savestate_load & ~load_prev_q;

  ss_watchdog #(
    .TO_W(TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wd_load),
    .load_val(WdLoad),
    .zero    (wd_zero)
  );

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    fail_d       = fail_q;
    save_st_d    = save_st_q;
    load_st_d    = load_st_q;
    pause_req_d  = pause_req_q;
    xfer_start_d = 1'b0;
    wd_load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Save wins a same-cycle collision; the load edge is simply lost.
        if (start_rise) begin
          state_d   = StAck;
          dir_d     = DirSave;
          fail_d    = 1'b0;
          save_st_d = StatusAccept;
        end else if (load_rise) begin
          state_d   = StAck;
          dir_d     = DirLoad;
          fail_d    = 1'b0;
          load_st_d = StatusAccept;
        end
      end

      StAck: begin
        save_st_d.ack = 1'b0;
        load_st_d.ack = 1'b0;
        pause_req_d   = 1'b1;
        wd_load       = 1'b1;
        state_d       = StPauseWait;
      end

      StPauseWait: begin
        if (pause_ack) begin
          state_d = StXfer;
        end else if (wd_zero) begin
          fail_d      = 1'b1;
          pause_req_d = 1'b0;
          wd_load     = 1'b1;
          state_d     = StResume;
        end
      end

      StXfer: begin
        xfer_start_d = 1'b1;
        wd_load      = 1'b1;
        state_d      = StXferWait;
      end

      StXferWait: begin
        // A done arriving on the expiry cycle still counts; only xfer_error decides.
        if (xfer_done) begin
          fail_d      = fail_q | xfer_error;
          pause_req_d = 1'b0;
          wd_load     = 1'b1;
          state_d     = StResume;
        end else if (wd_zero) begin
          fail_d      = 1'b1;
          pause_req_d = 1'b0;
          wd_load     = 1'b1;
          state_d     = StResume;
        end
      end

      StResume: begin
        if (!pause_ack) begin
          state_d = StDone;
        end else if (wd_zero) begin
          fail_d  = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        if (dir_q == DirLoad) begin
          load_st_d = finish_status(load_st_q, fail_q);
        end else begin
          save_st_d = finish_status(save_st_q, fail_q);
        end
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      dir_q        <= DirSave;
      fail_q       <= 1'b0;
      // Preset high so a request already asserted at reset release is not an edge.
      start_prev_q <= 1'b1;
      load_prev_q  <= 1'b1;
      save_st_q    <= StatusIdle;
      load_st_q    <= StatusIdle;
      pause_req_q  <= 1'b0;
      xfer_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      fail_q       <= fail_d;
      start_prev_q <= savestate_start;
      load_prev_q  <= savestate_load;
      save_st_q    <= save_st_d;
      load_st_q    <= load_st_d;
      pause_req_q  <= pause_req_d;
      xfer_start_q <= xfer_start_d;
    end
  end

  assign savestate_start_ack  = save_st_q.ack;
  assign savestate_start_busy = save_st_q.busy;
  assign savestate_start_ok   = save_st_q.ok;
  assign savestate_start_err  = save_st_q.err;

  assign savestate_load_ack  = load_st_q.ack;
  assign savestate_load_busy = load_st_q.busy;
  assign savestate_load_ok   = load_st_q.ok;
  assign savestate_load_err  = load_st_q.err;

  assign pause_req  = pause_req_q;
  assign xfer_start = xfer_start_q;
  assign xfer_dir   = dir_q;

endmodule
